// File: rtl/bytecode_decoder.sv
// Integer JVM bytecode subset decoder/executor on an internal operand stack.
// IDLE -> DECODE -> (MUL) -> WB; WB commits stack/depth and raises done into the next IDLE cycle.
module bytecode_decoder #(
  parameter int byte_width       = 8,
  parameter int data_width       = 32,
  parameter int stack_depth      = 8,
  parameter int stack_addr_width = 3,
  parameter int mul_cycles       = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [byte_width-1:0]       opcode,
  output logic                        ready,
  output logic                        done,
  output logic [data_width-1:0]       tos,
  output logic [stack_addr_width:0]   depth,
  output logic [1:0]                  error
);

  localparam logic [1:0] IDLE = 2'd0, DECODE = 2'd1, MUL = 2'd2, WB = 2'd3;
  localparam logic [1:0] E_OK = 2'd0, E_ILL = 2'd1, E_UNDER = 2'd2, E_OVER = 2'd3;
  localparam logic [2:0] K_NONE = 3'd0, K_PUSH = 3'd1, K_POP = 3'd2, K_BIN = 3'd3, K_REPL = 3'd4;
  localparam int cnt_w = $clog2(mul_cycles + 1);
  localparam int dw    = stack_addr_width + 1;

  logic [1:0]                  state;
  logic [byte_width-1:0]       op_q;
  logic [data_width-1:0]       stk [stack_depth];
  logic [2:0]                  kind_q, dec_kind;
  logic [1:0]                  err_q, dec_err;
  logic [data_width-1:0]       res_q, dec_res, mcand, mplier, acc, acc_nxt;
  logic [cnt_w-1:0]            cnt;
  logic [stack_addr_width-1:0] push_i, top_i, sec_i;
  logic [dw-1:0]               need;
  logic                        room, is_mul;
  logic [data_width-1:0]       a, b;
  logic [byte_width-1:0]       kval;

  assign push_i  = depth[stack_addr_width-1:0];
  assign top_i   = push_i - stack_addr_width'(1);
  assign sec_i   = push_i - stack_addr_width'(2);
  assign b       = stk[top_i];
  assign a       = stk[sec_i];
  assign ready   = (state == IDLE);
  assign tos     = (depth == '0) ? '0 : b;
  assign kval    = op_q - byte_width'(3);
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  // Classify the latched opcode; fault priority is illegal > underflow > overflow.
  always_comb begin
    dec_kind = K_NONE;
    dec_err  = E_OK;
    dec_res  = '0;
    need     = '0;
    room     = 1'b0;
    is_mul   = 1'b0;
    case (op_q)
      8'h00: ;
      8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08: begin
        dec_kind = K_PUSH;
        room     = 1'b1;
        dec_res  = {{(data_width-byte_width){kval[byte_width-1]}}, kval};
      end
      8'h57: begin dec_kind = K_POP;  need = dw'(1); end
      8'h59: begin dec_kind = K_PUSH; need = dw'(1); room = 1'b1; dec_res = b; end
      8'h60: begin dec_kind = K_BIN;  need = dw'(2); dec_res = a + b; end
      8'h64: begin dec_kind = K_BIN;  need = dw'(2); dec_res = a - b; end
      8'h68: begin dec_kind = K_BIN;  need = dw'(2); is_mul = 1'b1; end
      8'h91: begin dec_kind = K_REPL; need = dw'(1); dec_res = {{(data_width-8){b[7]}}, b[7:0]}; end
      default: dec_err = E_ILL;
    endcase
    if (dec_err == E_OK) begin
      if (depth < need)                            dec_err = E_UNDER;
      else if (room && depth == dw'(stack_depth))  dec_err = E_OVER;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      depth <= '0;
      done  <= 1'b0;
      error <= E_OK;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:   if (start) state <= DECODE;
        DECODE: state <= (dec_err == E_OK && is_mul) ? MUL : WB;
        MUL:    if (cnt == cnt_w'(mul_cycles - 1)) state <= WB;
        WB: begin
          state <= IDLE;
          done  <= 1'b1;
          error <= err_q;
          if (err_q == E_OK) begin
            case (kind_q)
              K_PUSH:        depth <= depth + dw'(1);
              K_POP, K_BIN:  depth <= depth - dw'(1);
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; control state alone defines visible outputs.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) op_q <= opcode;
      DECODE: begin
        kind_q <= dec_kind;
        err_q  <= dec_err;
        res_q  <= dec_res;
        mcand  <= a;
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end
      MUL: begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + cnt_w'(1);
        if (cnt == cnt_w'(mul_cycles - 1)) res_q <= acc_nxt;
      end
      WB: begin
        if (reset && err_q == E_OK) begin
          case (kind_q)
            K_PUSH: stk[push_i] <= res_q;
            K_BIN:  stk[sec_i]  <= res_q;
            K_REPL: stk[top_i]  <= res_q;
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bytecode_decoder.sv
// Scoreboard bench: stimulus pushes expected retirement results, a monitor checks each done pulse.
module tb_bytecode_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  opcode = 8'h00;
  logic        ready, done;
  logic [31:0] tos;
  logic [3:0]  depth;
  logic [1:0]  error;

  typedef struct {
    logic [31:0] t;
    logic [3:0]  d;
    logic [1:0]  e;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  bytecode_decoder dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .ready(ready), .done(done), .tos(tos), .depth(depth), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 expected none (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("tos", tos, e.t);
          check("depth", 32'(depth), 32'(e.d));
          check("error", 32'(error), 32'(e.e));
        end
      end
    end
  end

  task automatic reset_dut();
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Issue one opcode when ready; elat is the expected number of ready-low cycles.
  task automatic issue(input logic [7:0] op, input logic [31:0] et, input logic [3:0] ed,
                       input logic [1:0] ee, input int elat);
    int w = 0;
    int n = 0;
    exp_t e;
    while (ready !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    if (w >= 200) check("ready_timeout", 32'(ready), 32'd1);
    e.t = et; e.d = ed; e.e = ee;
    sb.push_back(e);
    start  = 1'b1;
    opcode = op;
    @(negedge clk);
    start = 1'b0;
    while (ready !== 1'b1 && n < 100) begin n++; @(negedge clk); end
    check($sformatf("latency_%02h", op), 32'(n), 32'(elat));
  endtask

  localparam logic [7:0] hold_ops [12] = '{8'h04, 8'h57, 8'h57, 8'h05, 8'h60, 8'h60,
                                          8'h60, 8'h57, 8'h57, 8'h91, 8'h57, 8'h57};
  localparam logic       hold_acc [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                          1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [31:0] hold_tos [12] = '{32'd1, 32'd0, 32'd0, 32'd2, 32'd0, 32'd0,
                                           32'd3, 32'd0, 32'd0, 32'd3, 32'd0, 32'd0};
  localparam logic [3:0]  hold_dep [12] = '{4'd1, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0,
                                           4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0};

  initial begin
    exp_t e;
    reset_dut();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_tos", tos, 32'd0);
    check("rst_error", 32'(error), 32'd0);

    issue(8'h03, 32'd0, 4'd1, 2'd0, 2);
    issue(8'h04, 32'd1, 4'd2, 2'd0, 2);

    // 5+2, dup, multiply -> 49
    reset_dut();
    issue(8'h08, 32'd5, 4'd1, 2'd0, 2);
    issue(8'h05, 32'd2, 4'd2, 2'd0, 2);
    issue(8'h60, 32'd7, 4'd1, 2'd0, 2);
    issue(8'h59, 32'd7, 4'd2, 2'd0, 2);
    issue(8'h68, 32'h31, 4'd1, 2'd0, 34);

    // Same sequence, reset in the middle of the multiply: no retirement may follow.
    reset_dut();
    issue(8'h08, 32'd5, 4'd1, 2'd0, 2);
    issue(8'h05, 32'd2, 4'd2, 2'd0, 2);
    issue(8'h60, 32'd7, 4'd1, 2'd0, 2);
    issue(8'h59, 32'd7, 4'd2, 2'd0, 2);
    start = 1'b1; opcode = 8'h68;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("mul_busy_ready", 32'(ready), 32'd0);
    check("mul_busy_depth", 32'(depth), 32'd2);
    reset = 1'b0;
    @(negedge clk);
    check("midmul_rst_ready", 32'(ready), 32'd1);
    check("midmul_rst_depth", 32'(depth), 32'd0);
    check("midmul_rst_done", 32'(done), 32'd0);
    check("midmul_rst_tos", tos, 32'd0);
    reset = 1'b1;
    repeat (40) @(negedge clk);

    // Build 0xC8 = 25*8, sign-extend the low byte, then an illegal opcode.
    reset_dut();
    issue(8'h08, 32'd5, 4'd1, 2'd0, 2);
    issue(8'h59, 32'd5, 4'd2, 2'd0, 2);
    issue(8'h68, 32'd25, 4'd1, 2'd0, 34);
    issue(8'h07, 32'd4, 4'd2, 2'd0, 2);
    issue(8'h59, 32'd4, 4'd3, 2'd0, 2);
    issue(8'h60, 32'd8, 4'd2, 2'd0, 2);
    issue(8'h68, 32'hC8, 4'd1, 2'd0, 34);
    issue(8'h91, 32'hFFFF_FFC8, 4'd1, 2'd0, 2);
    issue(8'h6F, 32'hFFFF_FFC8, 4'd1, 2'd1, 2);
    issue(8'h50, 32'hFFFF_FFC8, 4'd1, 2'd1, 2);

    // Underflow on empty, fill to full, overflow, then recover.
    reset_dut();
    issue(8'h60, 32'd0, 4'd0, 2'd2, 2);
    for (int i = 1; i <= 8; i++) issue(8'h04, 32'd1, 4'(i), 2'd0, 2);
    issue(8'h04, 32'd1, 4'd8, 2'd3, 2);
    issue(8'h57, 32'd1, 4'd7, 2'd0, 2);
    issue(8'h05, 32'd2, 4'd8, 2'd0, 2);
    issue(8'h64, 32'hFFFF_FFFF, 4'd7, 2'd0, 2);
    issue(8'h02, 32'hFFFF_FFFF, 4'd8, 2'd0, 2);
    issue(8'h59, 32'hFFFF_FFFF, 4'd8, 2'd3, 2);
    issue(8'h68, 32'd1, 4'd7, 2'd0, 34);
    issue(8'h00, 32'd1, 4'd7, 2'd0, 2);

    // start held high: only opcodes present while ready=1 execute.
    reset_dut();
    for (int i = 0; i < 12; i++) begin
      start  = 1'b1;
      opcode = hold_ops[i];
      check($sformatf("hold_ready_%0d", i), 32'(ready), 32'(hold_acc[i]));
      if (hold_acc[i]) begin
        e.t = hold_tos[i]; e.d = hold_dep[i]; e.e = 2'd0;
        sb.push_back(e);
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("hold_final_depth", 32'(depth), 32'd1);
    check("hold_final_tos", tos, 32'd3);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
